// File: rtl/keypad_encoder.sv
// ---------------------------------------------------------------------------
// keypad_encoder
//   Front-panel input block of the microwave timer. Scans a 4x3 matrix
//   keypad one column at a time, debounces press and release, encodes the
//   accepted key and shifts digits into the BCD time registers that also
//   feed the seven-segment display path. Clear (*) and start (#) are
//   reported to the control FSM.
//
// Parameters
//   SCAN_CYCLES     cycles each column is driven before rows are sampled
//   DEBOUNCE_CYCLES stable cycles required for both press and release
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   row_sense    keypad rows, active-low, already synchronised
//   col_drive    keypad columns, active-low, one-hot-low
//   load_en      digit entry allowed (low while cooking)
//   clear        synchronous clear of the digit registers
//   sec_ones     BCD seconds ones
//   sec_tens     BCD seconds tens (0-5)
//   min          BCD minutes
//   key_valid    one-cycle pulse per debounced press
//   key_code     code of the last accepted key (0-9, *=A, #=B)
//   start_pulse  one-cycle pulse on a # press
//   entry_err    one-cycle pulse when a digit is rejected
// ---------------------------------------------------------------------------
module keypad_encoder #(
  parameter int SCAN_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_sense,
  output logic [2:0] col_drive,
  input  logic       load_en,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       start_pulse,
  output logic       entry_err
);

  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [3:0] CODE_STAR = 4'hA;
  localparam logic [3:0] CODE_HASH = 4'hB;

  logic [1:0]    state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] min_q, min_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       start_q, start_d;
  logic       err_q, err_d;

  logic       accept;
  logic [1:0] next_col;
  logic [1:0] low_row;
  logic       any_low;
  logic       all_high;
  logic [3:0] key_w;

  assign next_col = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
  assign any_low  = ~&row_sense;
  assign all_high = &row_sense;

  // Lowest-index low row wins when several rows read low together.
  always_comb begin
    if      (!row_sense[0]) low_row = 2'd0;
    else if (!row_sense[1]) low_row = 2'd1;
    else if (!row_sense[2]) low_row = 2'd2;
    else                    low_row = 2'd3;
  end

  // Encode the latched row/column into the key code.
  always_comb begin
    key_w = 4'h0;
    if (row_q != 2'd3) begin
      key_w = ({2'b00, row_q} * 4'd3) + {2'b00, col_q} + 4'd1;
    end else begin
      case (col_q)
        2'd0:    key_w = CODE_STAR;
        2'd1:    key_w = 4'd0;
        default: key_w = CODE_HASH;
      endcase
    end
  end

  // Scan / debounce state machine.
  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    accept     = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (any_low) begin
            // Column stays driven; only the row is captured.
            row_d    = low_row;
            db_cnt_d = '0;
            state_d  = ST_DEBOUNCE;
          end else begin
            col_d = next_col;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (!row_sense[row_q]) begin
          if (db_cnt_q == DB_LAST) begin
            state_d = ST_HELD;
            accept  = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          // Bounce: drop the candidate and move on to the next column.
          state_d    = ST_SCAN;
          col_d      = next_col;
          scan_cnt_d = '0;
        end
      end

      ST_HELD: begin
        if (all_high) begin
          state_d  = ST_RELEASE;
          db_cnt_d = '0;
        end
      end

      ST_RELEASE: begin
        if (all_high) begin
          if (db_cnt_q == DB_LAST) begin
            state_d    = ST_SCAN;
            col_d      = next_col;
            scan_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
        end
      end

      default: begin
        state_d    = ST_SCAN;
        col_d      = 2'd0;
        scan_cnt_d = '0;
        db_cnt_d   = '0;
      end
    endcase
  end

  // Key action on acceptance and the synchronous clear of the digits.
  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    min_d   = min_q;
    code_d  = code_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;

    if (accept) begin
      valid_d = 1'b1;
      code_d  = key_w;
      if (key_w == CODE_HASH) begin
        start_d = 1'b1;
      end else if (key_w == CODE_STAR) begin
        if (load_en) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          min_d  = 4'd0;
        end
      end else if (load_en) begin
        // A shift moves sec_ones into sec_tens, which must stay 0-5.
        if (ones_q <= 4'd5) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = key_w;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (clear) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
      min_d  = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      min_q      <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      min_q      <= min_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    case (col_q)
      2'd0:    col_drive = 3'b110;
      2'd1:    col_drive = 3'b101;
      default: col_drive = 3'b011;
    endcase
  end

  assign sec_ones    = ones_q;
  assign sec_tens    = tens_q;
  assign min         = min_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign start_pulse = start_q;
  assign entry_err   = err_q;

endmodule
